// File: rtl/rwt_dac_pkg.sv
// ---------------------------------------------------------------------------
// rwt_dac_pkg
// Shared constants, the source FSM state type and the channel-packing helpers
// used by the RWT DAC stream source and its frame FIFO.
// ---------------------------------------------------------------------------
package rwt_dac_pkg;

    localparam int SAMPLE_W = 16;
    localparam int MAX_CH   = 4;
    localparam int DATA_W   = 64;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } dac_src_state_t;

    // Number of set bits in a 4-bit enable mask (0..4).
    function automatic logic [2:0] popcount4(input logic [MAX_CH-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    // Lane index of the k-th set bit of en, counting from bit 0 upwards.
    // Returns 0 when en has fewer than k+1 set bits.
    function automatic logic [1:0] nth_set_lane(input logic [MAX_CH-1:0] en,
                                                input logic [1:0]        k);
        logic [1:0] lane;
        logic [2:0] seen;
        lane = 2'd0;
        seen = 3'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (en[i]) begin
                if (seen == {1'b0, k}) begin
                    lane = 2'(i);
                end
                seen = seen + 3'd1;
            end
        end
        return lane;
    endfunction

endpackage

// File: rtl/rwt_dac_frame_fifo.sv
// ---------------------------------------------------------------------------
// rwt_dac_frame_fifo
// Synchronous single-clock FIFO of whole DAC frames.
//   clk      in   clock
//   resetn   in   synchronous active-low reset (empties the FIFO)
//   i_flush  in   synchronous clear, same effect as reset on the pointers
//   i_push   in   write i_din (ignored when full)
//   i_din    in   frame to write
//   i_pop    in   advance the head (ignored when empty)
//   o_dout   out  current head frame, taken from the storage registers
//   o_full   out  no free entry
//   o_empty  out  no valid entry
// A push and a pop in the same cycle are independent: on an empty FIFO the
// pop is ignored and the push lands, so nothing falls through.
// ---------------------------------------------------------------------------
module rwt_dac_frame_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push && resetn && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rwt_dac_stream_source.sv
// ---------------------------------------------------------------------------
// rwt_dac_stream_source
// Packs a channel-interleaved 16-bit sample stream into 64-bit DAC frames,
// buffers whole frames and serves one frame per DAC consume strobe.
//   clk              in   DAC-domain clock
//   resetn           in   synchronous active-low reset
//   s_axis_tdata     in   sample, interleaved over enabled channels (ascending)
//   s_axis_tvalid    in   sample valid
//   s_axis_tready    out  sample accepted when tvalid && tready
//   dac_enable       in   per-channel enable from the DAC core
//   dac_valid        in   per-channel consume strobe from the DAC core
//   dac_data         out  lane i = bits [16i+15:16i]
//   active           out  FSM is in RUN
//   underflow        out  one-cycle pulse per strobe that found no frame
//   underflow_count  out  saturating underflow count, cleared by reset only
// ---------------------------------------------------------------------------
module rwt_dac_stream_source
    import rwt_dac_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int UNDERFLOW_HOLD = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [MAX_CH-1:0]   dac_enable,
    input  logic [MAX_CH-1:0]   dac_valid,
    output logic [DATA_W-1:0]   dac_data,
    output logic                active,
    output logic                underflow,
    output logic [15:0]         underflow_count
);

    localparam logic [MAX_CH-1:0] CH_MASK = MAX_CH'((1 << NUM_CH) - 1);

    dac_src_state_t      r_state;
    logic [MAX_CH-1:0]   r_en_prev;
    logic [1:0]          r_k;
    logic [DATA_W-1:0]   r_frame;
    logic [DATA_W-1:0]   r_dac_data;
    logic                r_active;
    logic                r_underflow;
    logic [15:0]         r_uf_count;

    logic [MAX_CH-1:0]   w_en_eff;
    logic [2:0]          w_n;
    logic                w_strobe;
    logic                w_en_chg;
    logic [1:0]          w_lane;
    logic                w_last;
    logic                w_tready;
    logic                w_acc;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_frame_next;
    logic [DATA_W-1:0]   w_fifo_dout;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign w_en_eff = dac_enable & CH_MASK;
    assign w_n      = popcount4(w_en_eff);
    assign w_strobe = |(dac_valid & w_en_eff);
    assign w_en_chg = (w_en_eff != r_en_prev);
    assign w_lane   = nth_set_lane(w_en_eff, r_k);
    // With N=0 the subtraction wraps to 7 and never matches; that case only
    // arises alongside an enable change, which blocks acceptance anyway.
    assign w_last   = ({1'b0, r_k} == (w_n - 3'd1));

    // Only the final sample of a frame needs FIFO space; partial frames live
    // in r_frame, so non-final samples are always accepted outside IDLE.
    assign w_tready = (r_state != IDLE) && !(w_last && w_fifo_full);
    // A handshake coinciding with an enable change is swallowed.
    assign w_acc    = s_axis_tvalid && w_tready && !w_en_chg;
    assign w_push   = w_acc && w_last;
    assign w_pop    = !w_en_chg && !w_fifo_empty &&
                      ((r_state == PRIME) || ((r_state == RUN) && w_strobe));

    always_comb begin
        w_frame_next = r_frame;
        w_frame_next[w_lane*SAMPLE_W +: SAMPLE_W] = s_axis_tdata;
    end

    rwt_dac_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (w_en_chg),
        .i_push  (w_push),
        .i_din   (w_frame_next),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_en_prev   <= '0;
            r_k         <= 2'd0;
            r_frame     <= '0;
            r_dac_data  <= '0;
            r_active    <= 1'b0;
            r_underflow <= 1'b0;
            r_uf_count  <= 16'd0;
        end else begin
            r_en_prev   <= w_en_eff;
            r_underflow <= 1'b0;
            if (w_en_chg) begin
                // Flush everything except the underflow count.
                r_state    <= IDLE;
                r_active   <= 1'b0;
                r_k        <= 2'd0;
                r_frame    <= '0;
                r_dac_data <= '0;
            end else begin
                if (w_acc) begin
                    if (w_last) begin
                        r_frame <= '0;
                        r_k     <= 2'd0;
                    end else begin
                        r_frame <= w_frame_next;
                        r_k     <= r_k + 2'd1;
                    end
                end
                case (r_state)
                    IDLE: begin
                        if (w_en_eff != '0) begin
                            r_state <= PRIME;
                        end
                    end
                    PRIME: begin
                        // Preload the first frame so it is on the bus at
                        // RUN entry; strobes here are ignored.
                        if (!w_fifo_empty) begin
                            r_state    <= RUN;
                            r_active   <= 1'b1;
                            r_dac_data <= w_fifo_dout;
                        end
                    end
                    RUN: begin
                        if (w_strobe) begin
                            if (!w_fifo_empty) begin
                                r_dac_data <= w_fifo_dout;
                            end else begin
                                r_underflow <= 1'b1;
                                if (r_uf_count != 16'hFFFF) begin
                                    r_uf_count <= r_uf_count + 16'd1;
                                end
                                if (UNDERFLOW_HOLD == 0) begin
                                    r_dac_data <= '0;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_axis_tready   = w_tready;
    assign dac_data        = r_dac_data;
    assign active          = r_active;
    assign underflow       = r_underflow;
    assign underflow_count = r_uf_count;

endmodule

// File: tb/tb_rwt_dac_stream_source.sv
// Directed scoreboard bench: two instances share the stimulus, one zeroing on
// underflow and one holding the last frame; a negedge monitor pops an expected
// entry for every frame the DUT presents (RUN entry or a served strobe).
module tb_rwt_dac_stream_source;

    logic        clk;
    logic        resetn;
    logic [15:0] tdata;
    logic        tvalid;
    logic [3:0]  en;
    logic [3:0]  dv;

    logic        tready,   tready_h;
    logic [63:0] ddata,    ddata_h;
    logic        act,      act_h;
    logic        uf,       uf_h;
    logic [15:0] ufc,      ufc_h;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] d;
        logic [63:0] dh;
        logic        u;
    } exp_t;
    exp_t sb[$];

    bit pend     = 1'b0;
    bit prev_act = 1'b0;

    rwt_dac_stream_source #(.NUM_CH(4), .FIFO_DEPTH(2), .UNDERFLOW_HOLD(0)) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .dac_enable(en), .dac_valid(dv), .dac_data(ddata),
        .active(act), .underflow(uf), .underflow_count(ufc)
    );

    rwt_dac_stream_source #(.NUM_CH(4), .FIFO_DEPTH(2), .UNDERFLOW_HOLD(1)) dut_h (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_h),
        .dac_enable(en), .dac_valid(dv), .dac_data(ddata_h),
        .active(act_h), .underflow(uf_h), .underflow_count(ufc_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [63:0] dh, input logic u);
        exp_t e;
        e.d = d; e.dh = dh; e.u = u;
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] s);
        tdata  = s;
        tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tready) break;
            tick();
        end
        if (!tready) chk("send_timeout", 64'(tready), 64'd1);
        tick();
        tvalid = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] m);
        dv = m;
        tick();
        dv = 4'h0;
    endtask

    task automatic wait_active();
        for (int i = 0; i < 50; i++) begin
            if (act) break;
            tick();
        end
        chk("wait_active", 64'(act), 64'd1);
    endtask

    // Monitor: a frame is presented on RUN entry and one cycle after each
    // strobe seen while RUN; any other cycle must carry no underflow pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            pend     = 1'b0;
            prev_act = 1'b0;
        end else begin
            if (pend || (act && !prev_act)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", ddata, 64'hx);
                end else begin
                    e = sb.pop_front();
                    chk("dac_data", ddata, e.d);
                    chk("dac_data_hold", ddata_h, e.dh);
                    chk("underflow", 64'(uf), 64'(e.u));
                    chk("underflow_hold", 64'(uf_h), 64'(e.u));
                end
            end else begin
                chk("stray_underflow", 64'({uf, uf_h}), 64'd0);
            end
            pend     = act && (|(dv & en));
            prev_act = act;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; tdata = 16'h0; tvalid = 1'b0; en = 4'h0; dv = 4'h0;
        repeat (3) tick();
        chk("rst_data",   ddata,        64'd0);
        chk("rst_tready", 64'(tready),  64'd0);
        chk("rst_active", 64'(act),     64'd0);
        chk("rst_uf",     64'(uf),      64'd0);
        chk("rst_count",  64'(ufc),     64'd0);
        resetn = 1'b1;

        // Basic order, all four channels.
        en = 4'hF;
        push_exp(64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 1'b0);
        push_exp(64'h0008_0007_0006_0005, 64'h0008_0007_0006_0005, 1'b0);
        for (int i = 1; i <= 8; i++) send(16'(i));
        wait_active();
        repeat (3) tick();
        strobe(4'hF);
        repeat (3) tick();
        chk("basic_count", 64'(ufc), 64'd0);

        // Sparse packing on lanes 1 and 3, then an underflow strobe.
        en = 4'b1010;
        tick();
        chk("chg_active", 64'(act), 64'd0);
        chk("chg_data", ddata, 64'd0);
        push_exp(64'hBBBB_0000_AAAA_0000, 64'hBBBB_0000_AAAA_0000, 1'b0);
        send(16'hAAAA);
        send(16'hBBBB);
        wait_active();
        tick();
        push_exp(64'd0, 64'hBBBB_0000_AAAA_0000, 1'b1);
        strobe(4'b1010);
        chk("sparse_uf_count",   64'(ufc),   64'd1);
        chk("sparse_uf_count_h", 64'(ufc_h), 64'd1);

        // Two frames on lanes 0,1; three back-to-back strobes.
        en = 4'h3;
        tick();
        push_exp(64'h0000_0000_2222_1111, 64'h0000_0000_2222_1111, 1'b0);
        push_exp(64'h0000_0000_4444_3333, 64'h0000_0000_4444_3333, 1'b0);
        push_exp(64'd0, 64'h0000_0000_4444_3333, 1'b1);
        push_exp(64'd0, 64'h0000_0000_4444_3333, 1'b1);
        send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
        wait_active();
        tick();
        dv = 4'h3;
        repeat (3) tick();
        dv = 4'h0;
        chk("uf_count3", 64'(ufc), 64'd3);
        tick();

        // Backpressure with N=1 and a two-entry FIFO.
        en = 4'h1;
        tick();
        push_exp(64'h0A01, 64'h0A01, 1'b0);
        push_exp(64'h0A02, 64'h0A02, 1'b0);
        push_exp(64'h0A03, 64'h0A03, 1'b0);
        push_exp(64'h0A04, 64'h0A04, 1'b0);
        send(16'h0A01); send(16'h0A02); send(16'h0A03);
        chk("bp_full_tready", 64'(tready), 64'd0);
        repeat (2) tick();
        chk("bp_still_full", 64'(tready), 64'd0);
        chk("bp_active", 64'(act), 64'd1);
        strobe(4'h1);
        chk("bp_after_pop", 64'(tready), 64'd1);
        tdata = 16'h0A04; tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        chk("bp_refull", 64'(tready), 64'd0);
        strobe(4'h1);
        tick();
        strobe(4'h1);
        tick();

        // Enable change with two samples pending; a sample coinciding with
        // the change must be dropped.
        en = 4'hF;
        tick();
        send(16'h5001); send(16'h5002);
        en = 4'h3; tdata = 16'hDEAD; tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        chk("en_chg_active", 64'(act), 64'd0);
        chk("en_chg_data",   ddata,    64'd0);
        chk("en_chg_tready", 64'(tready), 64'd0);
        chk("en_chg_count",  64'(ufc), 64'd3);
        push_exp(64'h0000_0000_6002_6001, 64'h0000_0000_6002_6001, 1'b0);
        send(16'h6001); send(16'h6002);
        wait_active();
        tick();

        // Reset mid-RUN with count 5 and one frame queued.
        push_exp(64'd0, 64'h0000_0000_6002_6001, 1'b1);
        push_exp(64'd0, 64'h0000_0000_6002_6001, 1'b1);
        strobe(4'h3);
        strobe(4'h3);
        chk("pre_rst_count", 64'(ufc), 64'd5);
        send(16'h7001); send(16'h7002);
        resetn = 1'b0;
        tick();
        chk("mid_rst_data",    ddata,       64'd0);
        chk("mid_rst_data_h",  ddata_h,     64'd0);
        chk("mid_rst_active",  64'(act),    64'd0);
        chk("mid_rst_tready",  64'(tready), 64'd0);
        chk("mid_rst_uf",      64'(uf),     64'd0);
        chk("mid_rst_count",   64'(ufc),    64'd0);
        chk("mid_rst_count_h", 64'(ufc_h),  64'd0);
        resetn = 1'b1;
        repeat (6) tick();
        chk("reprime_idle", 64'(act), 64'd0);
        push_exp(64'h0000_0000_8002_8001, 64'h0000_0000_8002_8001, 1'b0);
        send(16'h8001); send(16'h8002);
        wait_active();
        repeat (3) tick();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
